lat_stb_seq: RTL



---
 rtl/lat_stb_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lat_stb_seq.sv
// LED-panel latch/strobe sequencer: counts shifted pixels, then issues LAT, STB and a row advance.
// Build macro LAT_STB_BCM_EN adds bit-plane weighting of the strobe and the PLANE output.
module lat_stb_seq #(
  parameter int PIX_PER_ROW = 64,
  parameter int ROWS        = 6,
  parameter int LAT_CYCLES  = 11,
  parameter int STB_CYCLES  = 51,
  parameter int ROW_W       = 6
`ifdef LAT_STB_BCM_EN
  ,
  parameter int PLANES      = 4
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PIX_VALID,
  output logic             LAT,
  output logic             STB,
  output logic [ROW_W-1:0] ROW,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic             OVERRUN
`ifdef LAT_STB_BCM_EN
  ,
  output logic [2:0]       PLANE
`endif
);

  // state  | meaning
  // S_IDLE | waiting for a completed row or a queued latch
  // S_LAT  | LAT high, down-counting the latch width
  // S_STB  | STB high, down-counting the strobe width; row advances as it ends

  localparam int PIX_W = (PIX_PER_ROW > 1) ? $clog2(PIX_PER_ROW) : 1;
  localparam int LAT_W = $clog2(LAT_CYCLES + 1);
`ifdef LAT_STB_BCM_EN
  localparam int STB_W = $clog2(STB_CYCLES + 1) + PLANES - 1;
`else
  localparam int STB_W = $clog2(STB_CYCLES + 1);
`endif
  localparam int TMR_W = (LAT_W > STB_W) ? LAT_W : STB_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LAT  = 2'd1,
    S_STB  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pix_cnt_q;
  logic               row_done;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [TMR_W-1:0]   stb_len;
  logic               pend_q, pend_d;
  logic               ovr_d;
  logic [ROW_W-1:0]   row_d;
  logic               row_last;
  logic               fd_d;

`ifdef LAT_STB_BCM_EN
  logic [2:0]         plane_q, plane_d;
  assign stb_len = TMR_W'(STB_CYCLES) << plane_q;
  assign PLANE   = plane_q;
`else
  assign stb_len = TMR_W'(STB_CYCLES);
`endif

  assign row_done = PIX_VALID && (pix_cnt_q == PIX_W'(PIX_PER_ROW - 1));
  assign row_last = (ROW == ROW_W'(ROWS - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pix_cnt_q <= '0;
    end else if (PIX_VALID) begin
      pix_cnt_q <= row_done ? '0 : pix_cnt_q + PIX_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pend_d  = pend_q;
    ovr_d   = OVERRUN;
    row_d   = ROW;
    fd_d    = 1'b0;
`ifdef LAT_STB_BCM_EN
    plane_d = plane_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (row_done || pend_q) begin
          state_d = S_LAT;
          tmr_d   = TMR_W'(LAT_CYCLES - 1);
          pend_d  = 1'b0;
        end
      end
      S_LAT: begin
        if (tmr_q == '0) begin
          state_d = S_STB;
          tmr_d   = stb_len - TMR_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
        if (row_done) begin
          if (pend_q) ovr_d = 1'b1;
          else        pend_d = 1'b1;
        end
      end
      S_STB: begin
        if (tmr_q == '0) begin
          row_d = row_last ? '0 : ROW + ROW_W'(1);
          fd_d  = row_last;
`ifdef LAT_STB_BCM_EN
          if (row_last) plane_d = (plane_q == 3'(PLANES - 1)) ? 3'd0 : plane_q + 3'd1;
`endif
          // The strobe end frees one latch slot, so a row completing now is absorbed, not an overrun.
          if (row_done || pend_q) begin
            state_d = S_LAT;
            tmr_d   = TMR_W'(LAT_CYCLES - 1);
            pend_d  = pend_q & row_done;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
          if (row_done) begin
            if (pend_q) ovr_d = 1'b1;
            else        pend_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      pend_q     <= 1'b0;
      LAT        <= 1'b0;
      STB        <= 1'b0;
      BUSY       <= 1'b0;
      ROW        <= '0;
      FRAME_DONE <= 1'b0;
      OVERRUN    <= 1'b0;
`ifdef LAT_STB_BCM_EN
      plane_q    <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      pend_q     <= pend_d;
      LAT        <= (state_d == S_LAT);
      STB        <= (state_d == S_STB);
      BUSY       <= (state_d != S_IDLE);
      ROW        <= row_d;
      FRAME_DONE <= fd_d;
      OVERRUN    <= ovr_d;
`ifdef LAT_STB_BCM_EN
      plane_q    <= plane_d;
`endif
    end
  end

endmodule
